// File: rtl/cnn_pkg.sv
// Shared constants, FSM state type and stream-word helpers for the CNN result output path.
package cnn_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_WORDS = 10;
  localparam int IDX_W     = 4;
  localparam logic [15:0] MAGIC = 16'hC1A5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    TAIL = 2'd3
  } wr_state_t;

  function automatic logic [DATA_W-1:0] header_word();
    return {MAGIC, 16'(NUM_WORDS)};
  endfunction

  function automatic logic [DATA_W-1:0] class_word(input logic [IDX_W-1:0] cls);
    return {{(DATA_W-IDX_W){1'b0}}, cls};
  endfunction

endpackage

// File: rtl/argmax_tracker.sv
// Streaming signed maximum; the first value after clr seeds it, ties keep the earliest index.
module argmax_tracker
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic [IDX_W-1:0]         idx,
  input  logic signed [DATA_W-1:0] value,
  output logic [IDX_W-1:0]         max_idx,
  output logic signed [DATA_W-1:0] max_val
);

  logic have_r;
  logic take_s;

  // strictly-greater replacement gives lowest-index tie-break
  always_comb begin
    take_s = en && (!have_r || (value > max_val));
  end

  // running maximum register
  always_ff @(posedge clk) begin
    if (rst) begin
      have_r  <= 1'b0;
      max_idx <= '0;
      max_val <= '0;
    end else if (clr) begin
      have_r  <= 1'b0;
      max_idx <= '0;
      max_val <= '0;
    end else if (take_s) begin
      have_r  <= 1'b1;
      max_idx <= idx;
      max_val <= value;
    end
  end

endmodule

// File: rtl/result_writer.sv
// Captures one vector of class scores and streams it as HEADER, scores, TRAILER(argmax)
// over a valid/ready word interface with fully registered outputs.
module result_writer
  import cnn_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] scores [NUM_WORDS-1:0],
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [IDX_W-1:0]         pred_class
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  wr_state_t                state_r, state_nxt;
  logic signed [DATA_W-1:0] score_buf_r [NUM_WORDS-1:0];
  logic [IDX_W-1:0]         idx_r, idx_nxt, idx_inc_s;
  logic [DATA_W-1:0]        data_nxt;
  logic                     valid_nxt, last_nxt, busy_nxt, done_nxt;
  logic [IDX_W-1:0]         pred_nxt;
  logic                     capture_s, trk_clr_s, trk_en_s, hs_s;
  logic [IDX_W-1:0]         trk_max_idx, final_idx_s;
  logic signed [DATA_W-1:0] trk_max_val;

  argmax_tracker u_argmax (
    .clk     (clk),
    .rst     (rst),
    .clr     (trk_clr_s),
    .en      (trk_en_s),
    .idx     (idx_r),
    .value   (score_buf_r[idx_r]),
    .max_idx (trk_max_idx),
    .max_val (trk_max_val)
  );

  // the tracker's register lags by one beat, so fold in the final score here for the trailer
  always_comb begin
    hs_s      = out_valid && out_ready;
    idx_inc_s = idx_r + 1'b1;
    if (score_buf_r[idx_r] > trk_max_val) begin
      final_idx_s = idx_r;
    end else begin
      final_idx_s = trk_max_idx;
    end
  end

  // next-state and next-output decode
  always_comb begin
    state_nxt = state_r;
    idx_nxt   = idx_r;
    data_nxt  = out_data;
    valid_nxt = out_valid;
    last_nxt  = out_last;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    pred_nxt  = pred_class;
    capture_s = 1'b0;
    trk_clr_s = 1'b0;
    trk_en_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt = HDR;
          capture_s = 1'b1;
          trk_clr_s = 1'b1;
          idx_nxt   = '0;
          data_nxt  = header_word();
          valid_nxt = 1'b1;
          last_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end else begin
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          busy_nxt  = 1'b0;
        end
      end
      HDR: begin
        if (hs_s) begin
          state_nxt = BODY;
          idx_nxt   = '0;
          data_nxt  = score_buf_r[0];
        end else begin
          state_nxt = HDR;
        end
      end
      BODY: begin
        if (hs_s) begin
          trk_en_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_nxt = TAIL;
            data_nxt  = class_word(final_idx_s);
            last_nxt  = 1'b1;
          end else begin
            idx_nxt  = idx_inc_s;
            data_nxt = score_buf_r[idx_inc_s];
          end
        end else begin
          state_nxt = BODY;
        end
      end
      TAIL: begin
        if (hs_s) begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
          last_nxt  = 1'b0;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          data_nxt  = '0;
          pred_nxt  = out_data[IDX_W-1:0];
        end else begin
          state_nxt = TAIL;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        data_nxt  = '0;
        valid_nxt = 1'b0;
        last_nxt  = 1'b0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // FSM state and registered stream outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      idx_r      <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pred_class <= '0;
    end else begin
      state_r    <= state_nxt;
      idx_r      <= idx_nxt;
      out_data   <= data_nxt;
      out_valid  <= valid_nxt;
      out_last   <= last_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pred_class <= pred_nxt;
    end
  end

  // score capture buffer, written only when a frame starts
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        score_buf_r[i] <= '0;
      end
    end else if (capture_s) begin
      for (int i = 0; i < NUM_WORDS; i++) begin
        score_buf_r[i] <= scores[i];
      end
    end
  end

endmodule

// File: tb/tb_result_writer.sv
// Randomized scoreboard bench for result_writer: expected frames come from a plain
// arithmetic model of the score vector and are checked by an independent stream monitor.
module tb_result_writer;
  import cnn_pkg::*;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        first;
  } beat_t;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     start;
  logic signed [DATA_W-1:0] scores [NUM_WORDS-1:0];
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_last;
  logic                     busy;
  logic                     done;
  logic [IDX_W-1:0]         pred_class;

  beat_t       exp_q[$];
  logic [3:0]  pred_q[$];
  int          errors = 0;
  int          checks = 0;
  int          total_beats = 0;
  int          cyc = 0;
  int          ready_mode = 0;
  int          tight = 0;
  int          hdr_cyc = 0;
  int          vals [10];
  logic        pv = 1'b0, pr = 1'b0, pl = 1'b0, prst = 1'b0;
  logic [31:0] pd = 32'd0;

  always #5 clk = ~clk;

  result_writer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .scores     (scores),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .pred_class (pred_class)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // sink readiness: 0 = always ready, 1 = random stalls, 2 = held off
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  // stream monitor / scoreboard
  initial forever begin
    @(negedge clk);
    if (!prst && pv && !pr) begin
      check("stall_valid", {31'd0, out_valid}, 32'd1);
      check("stall_data", out_data, pd);
      check("stall_last", {31'd0, out_last}, {31'd0, pl});
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got 0x%08h expected no beat", out_data);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", out_data, e.data);
        check("beat_last", {31'd0, out_last}, {31'd0, e.last});
        if (tight != 0) begin
          if (e.first) hdr_cyc = cyc;
          else if (e.last) check("frame_cycles", cyc - hdr_cyc, NUM_WORDS + 1);
        end
      end
      total_beats++;
    end
    if (done) begin
      if (pred_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected 0");
      end else begin
        logic [3:0] p;
        p = pred_q.pop_front();
        check("pred_class", {28'd0, pred_class}, {28'd0, p});
      end
    end
    pv   = out_valid;
    pr   = out_ready;
    pd   = out_data;
    pl   = out_last;
    prst = rst;
  end

  // enter at posedge+1, leave at posedge+1
  task automatic send_frame();
    int bi;
    int guard;
    guard = 0;
    while (busy && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    for (int i = 0; i < 10; i++) scores[i] = vals[i];
    start = 1'b1;
    bi = 0;
    for (int i = 1; i < 10; i++) if (vals[i] > vals[bi]) bi = i;
    exp_q.push_back('{data: {16'hC1A5, 16'd10}, last: 1'b0, first: 1'b1});
    for (int i = 0; i < 10; i++) exp_q.push_back('{data: vals[i], last: 1'b0, first: 1'b0});
    exp_q.push_back('{data: 32'(bi), last: 1'b1, first: 1'b0});
    pred_q.push_back(4'(bi));
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) scores[i] = $urandom();
    @(negedge clk);
    check("start_valid", {31'd0, out_valid}, 32'd1);
    check("start_busy", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || pred_q.size() != 0 || busy) && guard < 3000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checks++;
    if (guard >= 3000) begin
      errors++;
      $display("FAIL frame_timeout: got %0d beats pending expected 0", exp_q.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int guard;
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < 10; i++) scores[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_pred", {28'd0, pred_class}, 32'd0);
    @(posedge clk);
    #1;

    // ascending scores, back-to-back beats
    tight = 1;
    for (int i = 0; i < 10; i++) vals[i] = i * 100;
    send_frame();
    wait_idle();
    tight = 0;
    check("pred_ascending", {28'd0, pred_class}, 32'd9);

    // tie keeps lowest index
    for (int i = 0; i < 10; i++) vals[i] = -5;
    vals[3] = 7;
    vals[6] = 7;
    send_frame();
    wait_idle();

    // most-negative value against all -1
    vals[0] = 32'h8000_0000;
    for (int i = 1; i < 10; i++) vals[i] = -1;
    send_frame();
    wait_idle();

    // ascending again under random back-pressure
    ready_mode = 1;
    for (int i = 0; i < 10; i++) vals[i] = i * 100;
    send_frame();
    wait_idle();

    // start re-pulsed mid-frame must be ignored
    for (int i = 0; i < 10; i++) vals[i] = $urandom();
    send_frame();
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) scores[i] = $urandom();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_restart", {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    wait_idle();
    ready_mode = 0;

    // reset while BODY presents idx 4
    for (int i = 0; i < 10; i++) vals[i] = $urandom_range(0, 1000) - 500;
    base = total_beats;
    send_frame();
    guard = 0;
    while (total_beats - base < 5 && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("reset_point_beats", total_beats - base, 32'd5);
    rst = 1'b1;
    ready_mode = 2;
    exp_q.delete();
    pred_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    check("abort_valid", {31'd0, out_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_pred", {28'd0, pred_class}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_last", {31'd0, out_last}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 10; i++) vals[i] = $urandom();
    send_frame();
    wait_idle();

    // random frames with narrow ranges to provoke ties
    for (int f = 0; f < 6; f++) begin
      ready_mode = f % 2;
      for (int i = 0; i < 10; i++) vals[i] = (f < 3) ? ($urandom_range(0, 6) - 3) : int'($urandom());
      send_frame();
      wait_idle();
    end

    repeat (4) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
